// File: rtl/menu_cursor_ctrl.sv
// Front-panel menu cursor: synchronises and debounces Prev/Next/Okay/Cancel, steps a wrap/saturate cursor with auto-repeat.
// Raw change held steady -> registered pulse/cursor update after DEBOUNCE_CYC+3 clk; no backpressure, every event is acted on.
module menu_cursor_ctrl #(
  parameter int DEBOUNCE_CYC     = 500000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000,
  parameter int MAX_INDEX        = 10,
  parameter int IDX_W            = 4,
  parameter int WRAP             = 1,
  parameter int BTN_ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       iButton,
  input  logic             iLoad,
  input  logic [IDX_W-1:0] iLoadIndex,
  output logic [IDX_W-1:0] oCursor_Index,
  output logic             oMoved,
  output logic             oOkay,
  output logic             oCancel
);

  localparam int               DB_W       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam int               RPT_W      = $clog2(REPEAT_DELAY_CYC + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY_CYC);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY_CYC - REPEAT_RATE_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(MAX_INDEX);

  logic [3:0]       r_sync1, r_sync2, r_deb, r_deb_d;
  logic [DB_W-1:0]  r_db_cnt [4];
  logic [RPT_W-1:0] r_rpt;
  logic [IDX_W-1:0] r_cursor;
  logic             r_moved, r_okay, r_cancel;

  logic [3:0]       w_synced, w_press;
  logic             w_single, w_tick, w_step_prev, w_step_next;
  logic [IDX_W-1:0] w_cur_nxt;

  // Synchronisers keep running while disabled so a held button is seen when en rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= iButton;
      r_sync2 <= r_sync1;
    end
  end

  assign w_synced = (BTN_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else if (!en) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 4; i++) begin
        if (w_synced[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= ~r_deb[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press  = r_deb & ~r_deb_d;
  assign w_single = r_deb[0] ^ r_deb[1];

  // Timer holds cycles since the press; after the first repeat it reloads so it revisits RPT_FIRST every rate period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt <= '0;
    end else if (!en || !w_single) begin
      r_rpt <= '0;
    end else if (|w_press[1:0]) begin
      r_rpt <= RPT_W'(1);
    end else if (r_rpt == RPT_FIRST) begin
      r_rpt <= RPT_RELOAD;
    end else begin
      r_rpt <= r_rpt + 1'b1;
    end
  end

  assign w_tick      = w_single & ~(|w_press[1:0]) & (r_rpt == RPT_FIRST);
  assign w_step_prev = r_deb[0] & ~r_deb[1] & (w_press[0] | w_tick);
  assign w_step_next = r_deb[1] & ~r_deb[0] & (w_press[1] | w_tick);

  always_comb begin
    w_cur_nxt = r_cursor;
    if (iLoad) begin
      w_cur_nxt = (iLoadIndex > IDX_MAX) ? IDX_MAX : iLoadIndex;
    end else if (w_step_next) begin
      w_cur_nxt = (r_cursor == IDX_MAX) ? ((WRAP != 0) ? '0 : IDX_MAX) : r_cursor + 1'b1;
    end else if (w_step_prev) begin
      w_cur_nxt = (r_cursor == '0) ? ((WRAP != 0) ? IDX_MAX : '0) : r_cursor - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cursor <= '0;
      r_moved  <= 1'b0;
      r_okay   <= 1'b0;
      r_cancel <= 1'b0;
    end else if (!en) begin
      r_cursor <= '0;
      r_moved  <= 1'b0;
      r_okay   <= 1'b0;
      r_cancel <= 1'b0;
    end else begin
      r_cursor <= w_cur_nxt;
      r_moved  <= (w_cur_nxt != r_cursor);
      r_okay   <= w_press[2] & ~w_press[3];
      r_cancel <= w_press[3];
    end
  end

  assign oCursor_Index = r_cursor;
  assign oMoved        = r_moved;
  assign oOkay         = r_okay;
  assign oCancel       = r_cancel;

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// Bench for menu_cursor_ctrl: wrapping and saturating instances share stimulus and are checked every cycle
// against an event-level model, with literal expectations pinning the directed scenarios.
module tb_menu_cursor_ctrl;
  localparam int D = 4, DLY = 20, RATE = 5, MAXI = 10, W = 4;

  logic         clk = 1'b0;
  logic         rst_n, en, iLoad;
  logic [3:0]   btn_p, iButton;
  logic [W-1:0] iLoadIndex;
  logic [W-1:0] o1_cur, o0_cur;
  logic         o1_mv, o1_ok, o1_cn, o0_mv, o0_ok, o0_cn;

  always #5 clk = ~clk;
  assign iButton = ~btn_p;

  menu_cursor_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE),
    .MAX_INDEX(MAXI), .IDX_W(W), .WRAP(1), .BTN_ACTIVE_LOW(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .iButton(iButton), .iLoad(iLoad), .iLoadIndex(iLoadIndex),
    .oCursor_Index(o1_cur), .oMoved(o1_mv), .oOkay(o1_ok), .oCancel(o1_cn));

  menu_cursor_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(DLY), .REPEAT_RATE_CYC(RATE),
    .MAX_INDEX(MAXI), .IDX_W(W), .WRAP(0), .BTN_ACTIVE_LOW(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .iButton(iButton), .iLoad(iLoad), .iLoadIndex(iLoadIndex),
    .oCursor_Index(o0_cur), .oMoved(o0_mv), .oOkay(o0_ok), .oCancel(o0_cn));

  int n_checks = 0, n_fail = 0;
  int mv1 = 0, mv0 = 0, okc = 0, cnc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state
  logic [3:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_debd = '0;
  int         m_run [4] = '{0, 0, 0, 0};
  int         m_age = 0, m_c1 = 0, m_c0 = 0;
  bit         m_mv1 = 0, m_mv0 = 0, m_ok = 0, m_cn = 0;

  function automatic int next_cur(int c, bit nx, bit pv, bit wrap, bit ld, int li);
    if (ld) return (li > MAXI) ? MAXI : li;
    if (nx) return wrap ? (c + 1) % (MAXI + 1) : ((c < MAXI) ? c + 1 : c);
    if (pv) return wrap ? (c + MAXI) % (MAXI + 1) : ((c > 0) ? c - 1 : c);
    return c;
  endfunction

  task automatic model_step();
    logic [3:0] synced, press;
    bit single, tick, sp, sn, anyp;
    int a, n1, n0;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_debd = '0; m_age = 0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      m_c1 = 0; m_c0 = 0; m_mv1 = 0; m_mv0 = 0; m_ok = 0; m_cn = 0;
      return;
    end
    synced = ~m_s2;
    press  = m_deb & ~m_debd;
    anyp   = press[0] | press[1];
    single = m_deb[0] ^ m_deb[1];
    a      = anyp ? 0 : m_age;
    tick   = single && !anyp && a >= DLY && ((a - DLY) % RATE == 0);
    sp     = m_deb[0] && !m_deb[1] && (press[0] || tick);
    sn     = m_deb[1] && !m_deb[0] && (press[1] || tick);
    if (!en) begin
      m_c1 = 0; m_c0 = 0; m_mv1 = 0; m_mv0 = 0; m_ok = 0; m_cn = 0;
      m_deb = '0; m_debd = '0; m_age = 0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
    end else begin
      n1 = next_cur(m_c1, sn, sp, 1'b1, iLoad, int'(iLoadIndex));
      n0 = next_cur(m_c0, sn, sp, 1'b0, iLoad, int'(iLoadIndex));
      m_mv1 = (n1 != m_c1); m_mv0 = (n0 != m_c0);
      m_c1 = n1; m_c0 = n0;
      m_ok = press[2] && !press[3];
      m_cn = press[3];
      m_age = single ? a + 1 : 0;
      m_debd = m_deb;
      // A button flips after D consecutive samples disagreeing with its stable state.
      for (int b = 0; b < 4; b++) begin
        if (synced[b] != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin m_deb[b] = ~m_deb[b]; m_run[b] = 0; end
        end else begin
          m_run[b] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = iButton;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("wrap_out{cur,mv,ok,cn}", {o1_cur, o1_mv, o1_ok, o1_cn}, {W'(m_c1), m_mv1, m_ok, m_cn});
      chk("sat_out{cur,mv,ok,cn}",  {o0_cur, o0_mv, o0_ok, o0_cn}, {W'(m_c0), m_mv0, m_ok, m_cn});
      if (rst_n) begin
        if (o1_mv) mv1++;
        if (o0_mv) mv0++;
        if (o1_ok) okc++;
        if (o1_cn) cnc++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_cnt();
    mv1 = 0; mv0 = 0; okc = 0; cnc = 0;
  endtask

  task automatic tap(input int b);
    btn_p[b] = 1'b1; cyc(8);
    btn_p[b] = 1'b0; cyc(10);
  endtask

  task automatic load(input int v);
    iLoad = 1'b1; iLoadIndex = W'(v); cyc(1);
    iLoad = 1'b0; iLoadIndex = '0; cyc(1);
  endtask

  initial begin
    btn_p = '0; en = 1'b1; iLoad = 1'b0; iLoadIndex = '0; rst_n = 1'b0;
    cyc(2);
    chk("reset_cursor", o1_cur, 0);
    chk("reset_pulses", {o1_mv, o1_ok, o1_cn}, 0);
    rst_n = 1'b1;
    cyc(10);

    // Bounce then a clean hold: a single step 7 cycles after the last edge
    clr_cnt();
    for (int k = 0; k < 10; k++) begin btn_p[1] = (k % 2 == 0); cyc(2); end
    chk("bounce_no_step", mv1, 0);
    btn_p[1] = 1'b1; cyc(6);
    chk("bounce_not_yet", o1_mv, 0);
    cyc(1);
    chk("bounce_moved", o1_mv, 1);
    chk("bounce_cur", o1_cur, 1);
    cyc(3); btn_p[1] = 1'b0; cyc(12);
    chk("bounce_once", mv1, 1);

    // Wrap versus saturate at both ends
    load(10);
    chk("load10_wrap", o1_cur, 10);
    chk("load10_sat", o0_cur, 10);
    clr_cnt(); tap(1);
    chk("next_wrap_cur", o1_cur, 0);
    chk("next_sat_cur", o0_cur, 10);
    chk("next_sat_nomove", mv0, 0);
    chk("next_wrap_move", mv1, 1);
    tap(0);
    chk("prev_wrap_cur", o1_cur, 10);
    chk("prev_sat_cur", o0_cur, 9);
    load(0); clr_cnt(); tap(0);
    chk("prev0_wrap_cur", o1_cur, 10);
    chk("prev0_sat_cur", o0_cur, 0);
    chk("prev0_sat_nomove", mv0, 0);

    // Auto-repeat: 40 debounced cycles of Prev from 5
    load(5); clr_cnt();
    btn_p[0] = 1'b1; cyc(40); btn_p[0] = 1'b0; cyc(15);
    chk("rpt_cur_wrap", o1_cur, 0);
    chk("rpt_cur_sat", o0_cur, 0);
    chk("rpt_steps", mv1, 5);
    cyc(30);
    chk("rpt_stopped", o1_cur, 0);

    // Simultaneous presses
    clr_cnt();
    btn_p[1:0] = 2'b11; cyc(30); btn_p[1:0] = 2'b00; cyc(12);
    chk("prevnext_nostep", mv1, 0);
    btn_p[3:2] = 2'b11; cyc(8); btn_p[3:2] = 2'b00; cyc(12);
    chk("okcan_cancel", cnc, 1);
    chk("okcan_okay", okc, 0);
    clr_cnt();
    btn_p[2] = 1'b1; cyc(40); btn_p[2] = 1'b0; cyc(12);
    chk("okay_norepeat", okc, 1);
    chk("okay_nocancel", cnc, 0);

    // Load clamps and wins over a same-cycle Next step
    clr_cnt();
    btn_p[1] = 1'b1; cyc(6);
    iLoad = 1'b1; iLoadIndex = 4'd14; cyc(1); iLoad = 1'b0; iLoadIndex = '0;
    chk("load_clamp_cur", o1_cur, 10);
    chk("load_clamp_mv", o1_mv, 1);
    chk("load_clamp_sat", o0_cur, 10);
    btn_p[1] = 1'b0; cyc(12);
    chk("load_step_lost", o1_cur, 10);
    clr_cnt(); load(10);
    chk("load_same_nomove", mv1, 0);

    // Enable dropped mid-repeat, then raised while still held
    load(3);
    btn_p[1] = 1'b1; cyc(30);
    chk("en_before", o1_cur, 5);
    en = 1'b0; cyc(1);
    chk("en_off_cur", o1_cur, 0);
    chk("en_off_mv", o1_mv, 0);
    clr_cnt(); cyc(10);
    chk("en_off_quiet", mv1 + okc + cnc, 0);
    en = 1'b1; cyc(4);
    chk("en_on_wait", o1_cur, 0);
    cyc(1);
    chk("en_on_step", o1_cur, 1);
    chk("en_on_mv", o1_mv, 1);
    cyc(5); btn_p[1] = 1'b0; cyc(12);
    chk("en_on_single", mv1, 1);

    // Reset mid-debounce clears outputs at once and loses the pending press
    btn_p[2] = 1'b1; cyc(3);
    rst_n = 1'b0; btn_p[2] = 1'b0; #1;
    chk("rst_async_cur_wrap", o1_cur, 0);
    chk("rst_async_cur_sat", o0_cur, 0);
    chk("rst_async_pulses", {o1_mv, o1_ok, o1_cn}, 0);
    cyc(3); rst_n = 1'b1; clr_cnt(); cyc(20);
    chk("rst_no_okay", okc, 0);
    chk("rst_cur", o1_cur, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
